port_ingress: RTL and testbench



---
 rtl/sram_ctl_pkg.sv | 32 +++
 rtl/ingress_fifo.sv | 56 +++++
 rtl/port_ingress.sv | 230 +++++++++++++++++++++++
 tb/tb_port_ingress.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctl_pkg.sv
// Shared types and constants for the SRAM switch control path.
package sram_ctl_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 64;
  localparam int unsigned ADDR_WIDTH_DEF = 12;

  // Header beat field positions
  localparam int unsigned DEST_LSB = 0;
  localparam int unsigned DEST_W   = 4;
  localparam int unsigned PRIO_LSB = 4;
  localparam int unsigned PRIO_W   = 3;

  localparam int unsigned SIZE_W        = 8;
  localparam int unsigned CNT_W         = 16;
  localparam int unsigned MAX_PKT_BEATS = 255;

  // Completed-packet descriptor handed to cache_manager
  typedef struct packed {
    logic [DEST_W-1:0] dest_port;
    logic [PRIO_W-1:0] prio;
    logic [SIZE_W-1:0] w_size;
  } desc_t;

  // Saturating counter add
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + (CNT_W + 1)'(inc);
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/ingress_fifo.sv
// Synchronous FIFO whose write side can be committed or rewound to the last commit.
// Only committed entries are visible to the read side.
module ingress_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             commit,
  input  logic             rewind,
  input  logic             pop,
  output logic [WIDTH-1:0] head_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    cm_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_next;
  logic             do_push;
  logic             do_pop;

  assign full_c  = (wr_ptr - rd_ptr) == PW'(DEPTH);
  assign empty_c = (rd_ptr == cm_ptr);
  assign head_c  = mem[rd_ptr[AW-1:0]];
  assign do_push = push & ~full_c & ~rewind;
  assign do_pop  = pop & ~empty_c;
  assign wr_next = wr_ptr + PW'(do_push);

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Write, commit and read pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      cm_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (rewind) wr_ptr <= cm_ptr;
      else        wr_ptr <= wr_next;
      if (commit && !rewind) cm_ptr <= wr_next;
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/port_ingress.sv
// Per-port ingress: header decode, payload staging, and single-request write-out.
module port_ingress
  import sram_ctl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned BUF_DEPTH  = 256,
  parameter int unsigned META_DEPTH = 8,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_sop,
  input  logic                  wr_eop,
  input  logic                  wr_vld,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_grant,
  input  logic [ADDR_WIDTH-1:0] alloc_addr,
  output logic                  wea,
  output logic [SIZE_W-1:0]     w_size,
  // "priority" is a reserved word, hence the prefix
  output logic [PRIO_W-1:0]     pkt_priority,
  output logic [DEST_W-1:0]     dest_port,
  output logic                  writing,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  output logic [CNT_W-1:0]      drop_cnt
);

  localparam int unsigned DESC_W = $bits(desc_t);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER} state_t;

  // Ingress packet tracking
  logic              in_pkt, in_pkt_n;
  logic [DEST_W-1:0] cur_dest, cur_dest_n;
  logic [PRIO_W-1:0] cur_prio, cur_prio_n;
  logic [SIZE_W-1:0] cur_size, cur_size_n;
  logic [1:0]        drop_inc;

  // Buffer handshakes
  logic                  pay_push, pay_commit, pay_rewind, pay_pop;
  logic                  pay_full, pay_empty;
  logic [DATA_WIDTH-1:0] pay_head;
  logic                  meta_push, meta_pop, meta_full, meta_empty;
  desc_t                 meta_in, meta_head;

  // Output side
  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] base, base_n;
  logic [SIZE_W-1:0]     beat, beat_n;
  logic                  issue;
  logic                  wea_n, writing_n;
  logic [SIZE_W-1:0]     w_size_n;
  logic [PRIO_W-1:0]     prio_n;
  logic [DEST_W-1:0]     dest_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] wdata_n;

  ingress_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(BUF_DEPTH)) u_pay (
    .clk       (clk),
    .rst       (rst),
    .push      (pay_push),
    .push_data (wr_data),
    .commit    (pay_commit),
    .rewind    (pay_rewind),
    .pop       (pay_pop),
    .head_c    (pay_head),
    .full_c    (pay_full),
    .empty_c   (pay_empty)
  );

  ingress_fifo #(.WIDTH(DESC_W), .DEPTH(META_DEPTH)) u_meta (
    .clk       (clk),
    .rst       (rst),
    .push      (meta_push),
    .push_data (meta_in),
    .commit    (meta_push),
    .rewind    (1'b0),
    .pop       (meta_pop),
    .head_c    (meta_head),
    .full_c    (meta_full),
    .empty_c   (meta_empty)
  );

  assign meta_in = '{dest_port: cur_dest, prio: cur_prio, w_size: cur_size + SIZE_W'(1)};

  // Ingress decode: header capture, payload staging, commit and drop decisions
  always_comb begin
    pay_push   = 1'b0;
    pay_commit = 1'b0;
    pay_rewind = 1'b0;
    meta_push  = 1'b0;
    drop_inc   = 2'd0;
    in_pkt_n   = in_pkt;
    cur_dest_n = cur_dest;
    cur_prio_n = cur_prio;
    cur_size_n = cur_size;
    if (wr_vld) begin
      if (wr_sop) begin
        // A header while a packet is open abandons the open one
        if (in_pkt) begin
          pay_rewind = 1'b1;
          drop_inc   = drop_inc + 2'd1;
        end
        if (wr_eop) begin
          drop_inc = drop_inc + 2'd1;
          in_pkt_n = 1'b0;
        end else begin
          in_pkt_n   = 1'b1;
          cur_dest_n = wr_data[DEST_LSB +: DEST_W];
          cur_prio_n = wr_data[PRIO_LSB +: PRIO_W];
          cur_size_n = '0;
        end
      end else if (in_pkt) begin
        if ((cur_size == SIZE_W'(MAX_PKT_BEATS)) || pay_full || (wr_eop && meta_full)) begin
          // Rest of a dropped packet falls through as out-of-packet beats
          pay_rewind = 1'b1;
          drop_inc   = 2'd1;
          in_pkt_n   = 1'b0;
        end else begin
          pay_push   = 1'b1;
          cur_size_n = cur_size + SIZE_W'(1);
          if (wr_eop) begin
            pay_commit = 1'b1;
            meta_push  = 1'b1;
            in_pkt_n   = 1'b0;
          end
        end
      end
    end
  end

  // Ingress tracking registers and drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      in_pkt   <= 1'b0;
      cur_dest <= '0;
      cur_prio <= '0;
      cur_size <= '0;
      drop_cnt <= '0;
    end else begin
      in_pkt   <= in_pkt_n;
      cur_dest <= cur_dest_n;
      cur_prio <= cur_prio_n;
      cur_size <= cur_size_n;
      drop_cnt <= sat_add(drop_cnt, drop_inc);
    end
  end

  // Output FSM next state and next registered outputs
  always_comb begin
    state_n   = state;
    base_n    = base;
    beat_n    = beat;
    issue     = 1'b0;
    pay_pop   = 1'b0;
    meta_pop  = 1'b0;
    wea_n     = 1'b0;
    writing_n = 1'b0;
    w_size_n  = w_size;
    prio_n    = pkt_priority;
    dest_n    = dest_port;
    addr_n    = write_address;
    wdata_n   = sram_wdata;
    case (state)
      S_IDLE: begin
        if (!meta_empty) begin
          state_n  = S_REQ;
          wea_n    = 1'b1;
          w_size_n = meta_head.w_size;
          prio_n   = meta_head.prio;
          dest_n   = meta_head.dest_port;
          beat_n   = '0;
        end
      end
      S_REQ: begin
        wea_n = 1'b1;
        if (wr_grant) begin
          wea_n   = 1'b0;
          base_n  = alloc_addr;
          issue   = 1'b1;
          state_n = S_XFER;
        end
      end
      S_XFER: issue = 1'b1;
      default: state_n = S_IDLE;
    endcase
    // First beat leaves in the grant cycle, the rest back to back
    if (issue) begin
      writing_n = 1'b1;
      pay_pop   = ~pay_empty;
      wdata_n   = pay_head;
      addr_n    = ((state == S_REQ) ? alloc_addr : base) + ADDR_WIDTH'(beat);
      beat_n    = beat + SIZE_W'(1);
      if (beat_n == w_size) begin
        meta_pop = 1'b1;
        beat_n   = '0;
        state_n  = S_IDLE;
      end
    end
  end

  // Output FSM state register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      base          <= '0;
      beat          <= '0;
      wea           <= 1'b0;
      writing       <= 1'b0;
      w_size        <= '0;
      pkt_priority  <= '0;
      dest_port     <= '0;
      write_address <= '0;
      sram_wdata    <= '0;
    end else begin
      state         <= state_n;
      base          <= base_n;
      beat          <= beat_n;
      wea           <= wea_n;
      writing       <= writing_n;
      w_size        <= w_size_n;
      pkt_priority  <= prio_n;
      dest_port     <= dest_n;
      write_address <= addr_n;
      sram_wdata    <= wdata_n;
    end
  end

endmodule

// File: tb/tb_port_ingress.sv
// Directed self-checking bench for port_ingress.
module tb_port_ingress;

  logic        clk;
  logic        rst;
  logic        wr_sop, wr_eop, wr_vld;
  logic [63:0] wr_data;
  logic        wr_grant;
  logic [11:0] alloc_addr;
  logic        wea;
  logic [7:0]  w_size;
  logic [2:0]  pkt_priority;
  logic [3:0]  dest_port;
  logic        writing;
  logic [11:0] write_address;
  logic [63:0] sram_wdata;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] hold_size;
  logic [3:0] hold_dest;
  logic [2:0] hold_prio;

  typedef struct {
    logic [63:0] hdr;
    int          n;
    int          gap;
    logic [11:0] alloc;
    logic [3:0]  exp_dest;
    logic [2:0]  exp_prio;
    logic [11:0] exp_last;
  } vec_t;

  vec_t vecs [5];

  port_ingress dut (
    .clk           (clk),
    .rst           (rst),
    .wr_sop        (wr_sop),
    .wr_eop        (wr_eop),
    .wr_vld        (wr_vld),
    .wr_data       (wr_data),
    .wr_grant      (wr_grant),
    .alloc_addr    (alloc_addr),
    .wea           (wea),
    .w_size        (w_size),
    .pkt_priority  (pkt_priority),
    .dest_port     (dest_port),
    .writing       (writing),
    .write_address (write_address),
    .sram_wdata    (sram_wdata),
    .drop_cnt      (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] pay_word(input logic [15:0] tag, input int b);
    logic [15:0] bb;
    bb = 16'(b);
    return {tag, bb, ~tag, ~bb};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit hold);
    tick();
    if (hold) begin
      chk("hold_wea",  64'(wea), 64'd1);
      chk("hold_size", 64'(w_size), 64'(hold_size));
      chk("hold_dest", 64'(dest_port), 64'(hold_dest));
      chk("hold_prio", 64'(pkt_priority), 64'(hold_prio));
    end
  endtask

  task automatic send_pkt(input logic [63:0] hdr, input int n, input logic [15:0] tag,
                          input int gap, input bit hold, input bit with_eop);
    wr_vld = 1'b1; wr_sop = 1'b1; wr_eop = 1'b0; wr_data = hdr;
    step(hold);
    for (int b = 0; b < n; b++) begin
      if (gap > 0 && b > 0) begin
        wr_vld = 1'b0; wr_sop = 1'b0; wr_eop = 1'b0;
        repeat (gap) step(hold);
      end
      wr_vld = 1'b1; wr_sop = 1'b0;
      wr_eop = with_eop && (b == n - 1);
      wr_data = pay_word(tag, b);
      step(hold);
    end
    wr_vld = 1'b0; wr_sop = 1'b0; wr_eop = 1'b0; wr_data = '0;
  endtask

  task automatic serve(input logic [3:0] d, input logic [2:0] p, input int n,
                       input logic [11:0] alloc, input logic [15:0] tag,
                       input logic [11:0] last);
    int t;
    t = 0;
    while (wea !== 1'b1 && t < 300) begin
      tick();
      t++;
    end
    chk("wea_up", 64'(wea), 64'd1);
    chk("req_size", 64'(w_size), 64'(n));
    chk("req_dest", 64'(dest_port), 64'(d));
    chk("req_prio", 64'(pkt_priority), 64'(p));
    wr_grant = 1'b1; alloc_addr = alloc;
    tick();
    wr_grant = 1'b0; alloc_addr = '0;
    for (int b = 0; b < n; b++) begin
      if (b > 0) tick();
      if (b == 0) chk("wea_after_grant", 64'(wea), 64'd0);
      chk("writing", 64'(writing), 64'd1);
      chk("wr_addr", 64'(write_address), 64'(12'(alloc + 12'(b))));
      chk("wr_data", sram_wdata, pay_word(tag, b));
      if (b == n - 1) chk("last_addr", 64'(write_address), 64'(last));
    end
    tick();
    chk("writing_end", 64'(writing), 64'd0);
  endtask

  initial begin
    rst = 1'b1; wr_sop = 1'b0; wr_eop = 1'b0; wr_vld = 1'b0; wr_data = '0;
    wr_grant = 1'b0; alloc_addr = '0;
    hold_size = '0; hold_dest = '0; hold_prio = '0;
    repeat (3) tick();
    chk("rst_wea", 64'(wea), 64'd0);
    chk("rst_writing", 64'(writing), 64'd0);
    chk("rst_w_size", 64'(w_size), 64'd0);
    chk("rst_prio", 64'(pkt_priority), 64'd0);
    chk("rst_dest", 64'(dest_port), 64'd0);
    chk("rst_addr", 64'(write_address), 64'd0);
    chk("rst_wdata", sram_wdata, 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    rst = 1'b0;
    tick();

    // Single packets with immediate grant: decode, latency, address wrap
    vecs[0] = '{64'h35, 4, 0, 12'h100, 4'h5, 3'h3, 12'h103};
    vecs[1] = '{64'h7A, 4, 0, 12'hFFE, 4'hA, 3'h7, 12'h001};
    vecs[2] = '{64'hF0, 1, 0, 12'h000, 4'h0, 3'h7, 12'h000};
    vecs[3] = '{64'h1234_5678_9ABC_DE81, 255, 0, 12'h800, 4'h1, 3'h0, 12'h8FE};
    vecs[4] = '{64'h4F, 2, 3, 12'hFFF, 4'hF, 3'h4, 12'h000};
    for (int i = 0; i < 5; i++) begin
      send_pkt(vecs[i].hdr, vecs[i].n, 16'(16'h1000 + i), vecs[i].gap, 1'b0, 1'b1);
      chk("eop_t1_wea", 64'(wea), 64'd0);
      tick();
      chk("eop_t2_wea", 64'(wea), 64'd1);
      serve(vecs[i].exp_dest, vecs[i].exp_prio, vecs[i].n, vecs[i].alloc,
            16'(16'h1000 + i), vecs[i].exp_last);
    end
    chk("drop_after_table", 64'(drop_cnt), 64'd0);

    // Grant withheld while two more packets arrive; in-order, stable request
    send_pkt(64'h61, 3, 16'h2001, 0, 1'b0, 1'b1);
    tick(); tick();
    hold_size = 8'd3; hold_dest = 4'h1; hold_prio = 3'h6;
    send_pkt(64'h02, 2, 16'h2002, 0, 1'b1, 1'b1);
    send_pkt(64'h53, 5, 16'h2003, 0, 1'b1, 1'b1);
    repeat (10) step(1'b1);
    serve(4'h1, 3'h6, 3, 12'h200, 16'h2001, 12'h202);
    serve(4'h2, 3'h0, 2, 12'h300, 16'h2002, 12'h301);
    serve(4'h3, 3'h5, 5, 12'h400, 16'h2003, 12'h404);

    // Malformed packets: sop+eop, oversize, sop mid-packet
    wr_vld = 1'b1; wr_sop = 1'b1; wr_eop = 1'b1; wr_data = 64'h11;
    tick();
    wr_vld = 1'b0; wr_sop = 1'b0; wr_eop = 1'b0;
    chk("drop_sop_eop", 64'(drop_cnt), 64'd1);
    send_pkt(64'h22, 256, 16'h3001, 0, 1'b0, 1'b1);
    chk("drop_oversize", 64'(drop_cnt), 64'd2);
    repeat (3) tick();
    chk("no_req_after_drops", 64'(wea), 64'd0);
    send_pkt(64'h33, 2, 16'h3002, 0, 1'b0, 1'b0);
    send_pkt(64'h46, 3, 16'h3003, 0, 1'b0, 1'b1);
    chk("drop_sop_mid", 64'(drop_cnt), 64'd3);
    serve(4'h6, 3'h4, 3, 12'h010, 16'h3003, 12'h012);

    // Payload beats with no preceding header are ignored silently
    for (int b = 0; b < 3; b++) begin
      wr_vld = 1'b1; wr_sop = 1'b0; wr_eop = (b == 2); wr_data = pay_word(16'h3100, b);
      tick();
    end
    wr_vld = 1'b0; wr_eop = 1'b0;
    repeat (3) tick();
    chk("orphan_wea", 64'(wea), 64'd0);
    chk("orphan_drop", 64'(drop_cnt), 64'd3);

    // Buffer exactly filled by two blocked packets; third is dropped
    send_pkt(64'h12, 200, 16'h4001, 0, 1'b0, 1'b1);
    send_pkt(64'h23, 56, 16'h4002, 0, 1'b0, 1'b1);
    send_pkt(64'h34, 2, 16'h4003, 0, 1'b0, 1'b1);
    chk("drop_overflow", 64'(drop_cnt), 64'd4);
    serve(4'h2, 3'h1, 200, 12'hF80, 16'h4001, 12'h047);
    serve(4'h3, 3'h2, 56, 12'h600, 16'h4002, 12'h637);
    repeat (4) tick();
    chk("overflow_no_extra", 64'(wea), 64'd0);

    // Descriptor FIFO full at eop: ninth packet dropped
    for (int i = 0; i < 9; i++)
      send_pkt(64'(8'h10 + 8'(i)), 1, 16'(16'h5000 + i), 0, 1'b0, 1'b1);
    repeat (2) tick();
    chk("drop_meta_full", 64'(drop_cnt), 64'd5);
    for (int i = 0; i < 8; i++)
      serve(4'(i), 3'h1, 1, 12'(i * 16), 16'(16'h5000 + i), 12'(i * 16));
    repeat (4) tick();
    chk("meta_full_no_extra", 64'(wea), 64'd0);

    // Reset in the middle of an 8-beat transfer
    send_pkt(64'h77, 8, 16'h6000, 0, 1'b0, 1'b1);
    tick(); tick();
    chk("pre_rst_wea", 64'(wea), 64'd1);
    wr_grant = 1'b1; alloc_addr = 12'h500;
    tick();
    wr_grant = 1'b0; alloc_addr = '0;
    tick();
    chk("pre_rst_writing", 64'(writing), 64'd1);
    chk("pre_rst_addr", 64'(write_address), 64'h501);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_wea", 64'(wea), 64'd0);
    chk("mid_rst_writing", 64'(writing), 64'd0);
    chk("mid_rst_w_size", 64'(w_size), 64'd0);
    chk("mid_rst_prio", 64'(pkt_priority), 64'd0);
    chk("mid_rst_dest", 64'(dest_port), 64'd0);
    chk("mid_rst_addr", 64'(write_address), 64'd0);
    chk("mid_rst_wdata", sram_wdata, 64'd0);
    chk("mid_rst_drop", 64'(drop_cnt), 64'd0);
    repeat (3) tick();
    chk("post_rst_writing", 64'(writing), 64'd0);
    chk("post_rst_wea", 64'(wea), 64'd0);
    send_pkt(64'h29, 3, 16'h7000, 0, 1'b0, 1'b1);
    serve(4'h9, 3'h2, 3, 12'h0A0, 16'h7000, 12'h0A2);
    chk("post_rst_drop", 64'(drop_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
